// File: rtl/td4_run_controller.sv
// ---------------------------------------------------------------------------
// td4_run_controller
//
// Program store and run-control sequencer for the 4-bit TD4-style core.
//
// The program lives in a 16x8 register file. The host fills it through WRITE
// commands while the core is halted. The core fetches from it combinationally:
// cpu_address goes in and cpu_instr comes out in the same cycle.
//
// The core advances only on cycles where cpu_step is high. This block
// decides when that happens:
//   HALT   - no steps
//   RUN    - one step every (div+1) cycles, with an optional address
//            breakpoint that halts instead of stepping
//   STEP   - exactly one step, then back to HALT
//   CPURST - holds the core in reset (cpu_rst_n low) for two cycles, then HALT
//
// Ports:
//   clk, n_reset          system clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   byte command handshake; a command is accepted on a
//                         clk edge when both are high
//   cmd_op, cmd_data      0 WRITE, 1 CTRL, 2 SET_DIV, 3 SET_BP, plus payload
//   cpu_address           core program counter
//   cpu_instr             program byte at cpu_address (combinational)
//   cpu_step              single-cycle core clock-enable
//   cpu_rst_n             core reset, active-low, registered
//   state                 0 HALT, 1 RUN, 2 STEP, 3 CPURST
//   bp_hit                sticky: a breakpoint stopped RUN
//   err                   sticky: a WRITE arrived outside HALT
//   step_count            saturating count of issued cpu_step pulses
// ---------------------------------------------------------------------------
module td4_run_controller #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [3:0]       cpu_address,
    output logic [7:0]       cpu_instr,
    output logic             cpu_step,
    output logic             cpu_rst_n,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic             err,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [1:0] {
        ST_HALT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_CPURST = 2'd3
    } run_state_t;

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_CTRL    = 2'd1;
    localparam logic [1:0] OP_SET_DIV = 2'd2;
    localparam logic [1:0] OP_SET_BP  = 2'd3;

    run_state_t       state_reg;
    run_state_t       state_next;
    logic [3:0]       wr_ptr_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_active_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             bp_en_reg;
    logic [3:0]       bp_addr_reg;
    logic             bp_hit_reg;
    logic             err_reg;
    logic             first_due_reg;
    logic             cpu_rst_n_reg;
    logic             rst_cnt_reg;
    logic [CNT_W-1:0] step_count_reg;
    logic [15:0][7:0] mem_words;

    logic cmd_fire;
    logic is_write;
    logic is_ctrl;
    logic is_set_div;
    logic is_set_bp;
    logic mem_we;
    logic run_entry;
    logic cpurst_entry;
    logic run_due;
    logic bp_block;
    logic step_pulse;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign cmd_ready    = (state_reg != ST_CPURST);
    assign cmd_fire     = cmd_valid & cmd_ready;
    assign is_write     = cmd_fire & (cmd_op == OP_WRITE);
    assign is_ctrl      = cmd_fire & (cmd_op == OP_CTRL);
    assign is_set_div   = cmd_fire & (cmd_op == OP_SET_DIV);
    assign is_set_bp    = cmd_fire & (cmd_op == OP_SET_BP);
    assign mem_we       = is_write & (state_reg == ST_HALT);
    assign run_entry    = is_ctrl & (cmd_data[1:0] == 2'b01);
    assign cpurst_entry = is_ctrl & (cmd_data[1:0] == 2'b11);

    // ------------------------------------------------------------------
    // Step generation. cpu_step is derived from registered state, but it
    // also looks at the live cpu_address so that the breakpoint can veto
    // the step that would execute the breakpoint instruction. The core's
    // PC is itself a register, so no combinational loop is formed.
    // ------------------------------------------------------------------
    assign run_due    = (state_reg == ST_RUN) && (div_cnt_reg == div_active_reg);
    assign bp_block   = run_due && bp_en_reg && (cpu_address == bp_addr_reg)
                        && !first_due_reg;
    assign step_pulse = (run_due && !bp_block) || (state_reg == ST_STEP);

    assign cpu_step   = step_pulse;
    assign cpu_rst_n  = cpu_rst_n_reg;
    assign state      = state_reg;
    assign bp_hit     = bp_hit_reg;
    assign err        = err_reg;
    assign step_count = step_count_reg;
    assign cpu_instr  = mem_words[cpu_address];

    // ------------------------------------------------------------------
    // Next state. The automatic transitions (breakpoint, end of STEP, end
    // of CPURST) are computed first. An accepted CTRL command then
    // overrides them, because a host command always has the final say.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (bp_block) state_next = ST_HALT;
            ST_STEP:   state_next = ST_HALT;
            ST_CPURST: if (rst_cnt_reg) state_next = ST_HALT;
            default:   state_next = state_reg;
        endcase
        if (is_ctrl) begin
            case (cmd_data[1:0])
                2'b00:   state_next = ST_HALT;
                2'b01:   state_next = ST_RUN;
                // A STEP request while running is read as "stop".
                2'b10:   state_next = (state_reg == ST_RUN) ? ST_HALT : ST_STEP;
                default: state_next = ST_CPURST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg      <= ST_HALT;
            cpu_rst_n_reg  <= 1'b0;
            rst_cnt_reg    <= 1'b0;
            wr_ptr_reg     <= 4'd0;
            div_reg        <= '0;
            div_active_reg <= '0;
            div_cnt_reg    <= '0;
            first_due_reg  <= 1'b0;
            bp_en_reg      <= 1'b0;
            bp_addr_reg    <= 4'd0;
            bp_hit_reg     <= 1'b0;
            err_reg        <= 1'b0;
            step_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cpu_rst_n_reg <= (state_next != ST_CPURST);

            // CPURST lasts two cycles. The counter is 0 in the first cycle
            // and 1 in the second.
            if (cpurst_entry)
                rst_cnt_reg <= 1'b0;
            else if (state_reg == ST_CPURST)
                rst_cnt_reg <= 1'b1;

            // Rate divider. The divisor is latched into div_active_reg on
            // every reload, so a SET_DIV never disturbs a period that is
            // already in progress.
            if (run_entry) begin
                div_cnt_reg    <= '0;
                div_active_reg <= div_reg;
            end else if (state_reg == ST_RUN) begin
                if (run_due) begin
                    div_cnt_reg    <= '0;
                    div_active_reg <= div_reg;
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end

            // The first due step after entering RUN skips the breakpoint
            // check, so the core can resume from the breakpoint address.
            if (run_entry)
                first_due_reg <= 1'b1;
            else if (run_due)
                first_due_reg <= 1'b0;

            if (run_entry)
                bp_hit_reg <= 1'b0;
            else if (bp_block)
                bp_hit_reg <= 1'b1;

            if (mem_we)
                wr_ptr_reg <= wr_ptr_reg + 4'd1;
            else if (is_ctrl && cmd_data[2])
                wr_ptr_reg <= 4'd0;

            if (is_write && (state_reg != ST_HALT))
                err_reg <= 1'b1;
            else if (is_ctrl && cmd_data[2])
                err_reg <= 1'b0;

            if (is_set_div)
                div_reg <= DIV_W'(cmd_data);

            if (is_set_bp) begin
                bp_en_reg   <= cmd_data[4];
                bp_addr_reg <= cmd_data[3:0];
            end

            // Entering CPURST clears the count. This takes priority over a
            // pulse issued in the same cycle.
            if (cpurst_entry)
                step_count_reg <= '0;
            else if (step_pulse && (step_count_reg != {CNT_W{1'b1}}))
                step_count_reg <= step_count_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Program store: one register per word. The whole store must clear on
    // the asynchronous reset, which rules out a RAM primitive.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mem
            logic [7:0] word_reg;
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset)
                    word_reg <= 8'h00;
                else if (mem_we && (wr_ptr_reg == 4'(gi)))
                    word_reg <= cmd_data;
            end
            assign mem_words[gi] = word_reg;
        end
    endgenerate

endmodule
